ula_arbiter: RTL and testbench
==============================

// Module: ula_arbiter
// PURPOSE
//  Shares one ULA between two requesters (0: execute stage, 1: address/branch unit).
//  Arbitrates between the requesters and drives registered operands and opcode into the ULA.
//  Waits the ULA's fixed latency, then returns Out plus flags to the winning requester.
//  Only one operation is in flight at a time. It sits between the issue logic and the ULA instance.
// PARAMETERS
//  DATA_W       32  operand/result width (matches ULA A/B/Out)
//  OP_W         5   ULA opcode width
//  ULA_LATENCY  1   clock edges from ULA inputs stable to ULA Out/flags valid; legal range 1..15
// PORTS
//  clock         in   1       single clock, rising edge
//  reset         in   1       synchronous, active-low
//  req0_valid    in   1       requester 0 has an operation
//  req0_ready    out  1       requester 0 accepted this cycle (when valid)
//  req0_a        in   DATA_W  operand A, requester 0
//  req0_b        in   DATA_W  operand B, requester 0
//  req0_opcode   in   OP_W    ULA opcode, requester 0
//  req1_valid, req1_ready, req1_a, req1_b, req1_opcode   same as req0_*, requester 1
//  ula_a         out  DATA_W  registered to ULA .A
//  ula_b         out  DATA_W  registered to ULA .B
//  ula_opcode    out  OP_W    registered to ULA .opcode
//  ula_out       in   DATA_W  ULA .Out
//  ula_zero, ula_overflow, ula_carry, ula_neg   in  1 each  ULA flags
//  rsp_valid     out  1       result held for owner
//  rsp_ready     in   1       owner consumes result
//  rsp_id        out  1       owner of result (0/1)
//  rsp_out       out  DATA_W  captured ULA Out
//  rsp_flags     out  4       captured {neg,carry,overflow,zero}
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset (reset==0 at an edge):
//   - state=IDLE, last_grant=1, so requester 0 wins first.
//   - ula_a=0, ula_b=0, ula_opcode=5'b00000 (add).
//   - rsp_valid=0, rsp_id=0, rsp_out=0, rsp_flags=0, busy=0, cnt=0.
//  FSM IDLE -> BUSY -> RESP -> IDLE
//   - IDLE:
//       - grant: both valid -> !last_grant; one valid -> that one; none -> no grant.
//       - reqN_ready=1 only in IDLE and only for the granted N. It is combinational from the valids.
//       - Accept edge: latch winner's a/b/opcode into ula_*, rsp_id=N, last_grant=N, cnt=ULA_LATENCY, go to BUSY.
//   - BUSY:
//       - ula_* held stable.
//       - cnt!=0: cnt--.
//       - cnt==0: capture ula_out and flags into rsp_*, set rsp_valid=1, go to RESP.
//       - BUSY lasts ULA_LATENCY+1 cycles. Accept edge to rsp_valid high = ULA_LATENCY+2 cycles.
//   - RESP:
//       - rsp_* held stable while rsp_ready=0.
//       - Edge with rsp_ready=1: rsp_valid=0, go to IDLE.
//       - No accept in the same cycle, so there is one bubble cycle between operations.
//  Rules:
//   - Both ready outputs stay 0 outside IDLE. Requesters must hold valid and operands until ready.
//   - A requester dropping valid before ready is legal; no operation is issued for it.
//   - The same requester alone may win back-to-back. Round-robin applies only when both are valid.
//   - reset asserted in BUSY/RESP aborts: the result is discarded and all state returns to reset values next edge.
//   - rsp_ready while rsp_valid=0 is ignored.
//   - No arithmetic is done here. rsp_out/rsp_flags are bit-exact copies of ULA outputs.
// CONFIGURATION
//  ULA_ARB_FIXED_PRIO_EN
//   - defined: requester 0 always wins when both are valid; last_grant is unused.
//   - undefined (default): round-robin as above.
// TESTING
//  Bench uses a ULA model (opcode 00000 = add, registered, ULA_LATENCY=1).
//  1 Reset, then idle:
//     - reset=0 for 2 edges.
//     - Required: ula_opcode=0, rsp_valid=0, busy=0, both ready=0.
//     - With no valids, state stays IDLE.
//  2 Single op:
//     - req0 a=32'h00000001, b=32'h7FFFFFFE, opcode=0.
//     - Required: req0_ready=1 in the accept cycle.
//     - Required: rsp_valid rises 3 cycles later with rsp_id=0, rsp_out=32'h7FFFFFFF, rsp_flags=4'b0000.
//  3 Overflow flags:
//     - req1 a=32'h7FFFFFFF, b=32'h00000001, add.
//     - Required: rsp_id=1, rsp_out=32'h80000000, rsp_flags=4'b1010 (neg, overflow).
//  4 Contention:
//     - Both valid continuously; rsp_ready=1.
//     - Required: grants alternate 0,1,0,1 over 4 ops.
//     - With ULA_ARB_FIXED_PRIO_EN: all 4 grants go to 0.
//  5 Backpressure:
//     - rsp_ready=0 for 5 cycles in RESP.
//     - Required: rsp_* stable, both ready=0.
//     - After rsp_ready=1: IDLE next edge, next accept one cycle later.
//  6 Reset mid-op:
//     - reset=0 during BUSY.
//     - Required: next edge busy=0, rsp_valid=0, last_grant=1, no response emitted.

Source files
------------

// File: rtl/ula_arbiter_if.sv
// ---------------------------------------------------------------------------
// ula_arbiter_if
// Purpose: bundles every bus signal around the ULA arbiter. This covers the
//          two requester handshakes, the registered ULA operand/opcode drive
//          plus the ULA result/flags, and the response handshake back to the
//          owning requester.
// Modports:
//   slave  - the arbiter's view. Requests, ULA results and rsp_ready come in.
//            Readies, ULA drive and rsp_* go out.
//   master - the surrounding environment's view (issue logic, ULA, owner).
// Signals:
//   reqN_valid/ready/a/b/opcode  requester N handshake and operands (N=0,1)
//   ula_a/ula_b/ula_opcode       registered drive into the ULA
//   ula_out, ula_zero/overflow/carry/neg   ULA result and flags
//   rsp_valid/ready/id/out/flags response to the owning requester
// ---------------------------------------------------------------------------
interface ula_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_opcode;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_opcode;

  logic [DATA_W-1:0] ula_a;
  logic [DATA_W-1:0] ula_b;
  logic [OP_W-1:0]   ula_opcode;
  logic [DATA_W-1:0] ula_out;
  logic              ula_zero;
  logic              ula_overflow;
  logic              ula_carry;
  logic              ula_neg;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_out;
  logic [3:0]        rsp_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_opcode,
    input  req1_valid, req1_a, req1_b, req1_opcode,
    output req0_ready, req1_ready,
    output ula_a, ula_b, ula_opcode,
    input  ula_out, ula_zero, ula_overflow, ula_carry, ula_neg,
    output rsp_valid, rsp_id, rsp_out, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_opcode,
    output req1_valid, req1_a, req1_b, req1_opcode,
    input  req0_ready, req1_ready,
    input  ula_a, ula_b, ula_opcode,
    output ula_out, ula_zero, ula_overflow, ula_carry, ula_neg,
    input  rsp_valid, rsp_id, rsp_out, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/ula_arbiter.sv
// ---------------------------------------------------------------------------
// ula_arbiter
// Purpose: shares one ULA between two requesters. Requester 0 is the execute
//          stage and requester 1 is the address/branch unit. The block picks
//          a winner and drives the winner's registered operands and opcode
//          into the ULA. It then waits out the ULA latency and hands the
//          captured Out and flags back to the winner. Only one operation is
//          in flight at a time.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-low
//   bus    - ula_arbiter_if.slave (requests, ULA drive/result, response)
//   busy   - high whenever the FSM is not IDLE
// Parameters: DATA_W (operand width), OP_W (opcode width),
//             ULA_LATENCY (ULA edges to valid Out, 1..15)
// Configuration macro: ULA_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins a tie
//   undefined -> round-robin on ties (default)
// ---------------------------------------------------------------------------
module ula_arbiter #(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 5,
  parameter int ULA_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  ula_arbiter_if.slave  bus,
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] ulaA_q, ulaA_d;
  logic [DATA_W-1:0] ulaB_q, ulaB_d;
  logic [OP_W-1:0]   ulaOpcode_q, ulaOpcode_d;
  logic              rspValid_q, rspValid_d;
  logic              rspId_q, rspId_d;
  logic [DATA_W-1:0] rspOut_q, rspOut_d;
  logic [3:0]        rspFlags_q, rspFlags_d;

  logic grant0;
  logic grant1;
  logic accept;

  // Grant selection. A lone valid requester always wins. The macro only
  // decides who wins a tie.
`ifdef ULA_ARB_FIXED_PRIO_EN
  assign grant0 = bus.req0_valid;
`else
  logic lastGrant_q;

  // lastGrant_q resets to 1 so that requester 0 wins the first tie.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || lastGrant_q);

  always_ff @(posedge clock) begin
    if (!reset)
      lastGrant_q <= 1'b1;
    else if (accept)
      lastGrant_q <= grant1;
  end
`endif

  assign grant1 = bus.req1_valid && !grant0;
  assign accept = (state_q == IDLE) && (grant0 || grant1);

  // Readies come straight from the valids, and only while IDLE.
  assign bus.req0_ready = (state_q == IDLE) && grant0;
  assign bus.req1_ready = (state_q == IDLE) && grant1;

  // Next-state logic. BUSY holds for ULA_LATENCY+1 cycles. The capture
  // happens on the edge where the counter has already reached zero, which
  // leaves the ULA at least its full latency.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ulaA_d      = ulaA_q;
    ulaB_d      = ulaB_q;
    ulaOpcode_d = ulaOpcode_q;
    rspValid_d  = rspValid_q;
    rspId_d     = rspId_q;
    rspOut_d    = rspOut_q;
    rspFlags_d  = rspFlags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ulaA_d      = grant1 ? bus.req1_a      : bus.req0_a;
          ulaB_d      = grant1 ? bus.req1_b      : bus.req0_b;
          ulaOpcode_d = grant1 ? bus.req1_opcode : bus.req0_opcode;
          rspId_d     = grant1;
          cnt_d       = 4'(ULA_LATENCY);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rspOut_d   = bus.ula_out;
          rspFlags_d = {bus.ula_neg, bus.ula_carry, bus.ula_overflow, bus.ula_zero};
          rspValid_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        // No new accept on this edge, which leaves one bubble cycle in IDLE.
        if (bus.rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. A reset in BUSY or RESP drops any pending result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ulaA_q      <= '0;
      ulaB_q      <= '0;
      ulaOpcode_q <= '0;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
      rspOut_q    <= '0;
      rspFlags_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ulaA_q      <= ulaA_d;
      ulaB_q      <= ulaB_d;
      ulaOpcode_q <= ulaOpcode_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspOut_q    <= rspOut_d;
      rspFlags_q  <= rspFlags_d;
    end
  end

  assign bus.ula_a      = ulaA_q;
  assign bus.ula_b      = ulaB_q;
  assign bus.ula_opcode = ulaOpcode_q;
  assign bus.rsp_valid  = rspValid_q;
  assign bus.rsp_id     = rspId_q;
  assign bus.rsp_out    = rspOut_q;
  assign bus.rsp_flags  = rspFlags_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ula_arbiter
// Purpose: directed, self-checking bench for ula_arbiter. A registered
//          one-cycle ULA model implements opcode 00000 (add) and its four
//          flags. Inputs change 1 ns after the rising edge, and outputs are
//          sampled in the same window, away from the edge.
// ---------------------------------------------------------------------------
module tb_ula_arbiter;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  logic clock;
  logic reset;
  logic busy;

  int checks;
  int errors;

  ula_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  ula_arbiter #(
    .DATA_W(DATA_W),
    .OP_W(OP_W),
    .ULA_LATENCY(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave),
    .busy(busy)
  );

  // 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered ULA model: add only, one edge of latency.
  logic [DATA_W:0] ulaSum;
  assign ulaSum = {1'b0, bus.ula_a} + {1'b0, bus.ula_b};

  always @(posedge clock) begin
    bus.ula_out      <= ulaSum[DATA_W-1:0];
    bus.ula_carry    <= ulaSum[DATA_W];
    bus.ula_neg      <= ulaSum[DATA_W-1];
    bus.ula_zero     <= (ulaSum[DATA_W-1:0] == '0);
    bus.ula_overflow <= (bus.ula_a[DATA_W-1] == bus.ula_b[DATA_W-1]) &&
                        (ulaSum[DATA_W-1] != bus.ula_a[DATA_W-1]);
  end

  // Watchdog so that the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic rspReady);
    bus.req0_valid  = v0;
    bus.req0_a      = a0;
    bus.req0_b      = b0;
    bus.req0_opcode = 5'b00000;
    bus.req1_valid  = v1;
    bus.req1_a      = a1;
    bus.req1_b      = b1;
    bus.req1_opcode = 5'b00000;
    bus.rsp_ready   = rspReady;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic expGrant;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    // 1: reset for two edges, then idle with no valids
    tick();
    tick();
    checkOutput("rst_ula_opcode", 64'(bus.ula_opcode), 64'd0);
    checkOutput("rst_ula_a", 64'(bus.ula_a), 64'd0);
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("rst_rsp_out", 64'(bus.rsp_out), 64'd0);
    checkOutput("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ready0", 64'(bus.req0_ready), 64'd0);
    checkOutput("rst_ready1", 64'(bus.req1_ready), 64'd0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    // 2: single op from requester 0
    applyStimulus(1'b1, 32'h00000001, 32'h7FFFFFFE, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("single_ready0", 64'(bus.req0_ready), 64'd1);
    checkOutput("single_ready1", 64'(bus.req1_ready), 64'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("single_busy", 64'(busy), 64'd1);
    checkOutput("single_ula_a", 64'(bus.ula_a), 64'h00000001);
    checkOutput("single_ula_b", 64'(bus.ula_b), 64'h7FFFFFFE);
    checkOutput("single_lat1", 64'(bus.rsp_valid), 64'd0);
    tick();
    checkOutput("single_lat2", 64'(bus.rsp_valid), 64'd0);
    tick();
    checkOutput("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("single_rsp_id", 64'(bus.rsp_id), 64'd0);
    checkOutput("single_rsp_out", 64'(bus.rsp_out), 64'h7FFFFFFF);
    checkOutput("single_rsp_flags", 64'(bus.rsp_flags), 64'b0000);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checkOutput("single_done_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("single_done_busy", 64'(busy), 64'd0);

    // 3: signed overflow from requester 1
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    #1;
    checkOutput("ovf_ready1", 64'(bus.req1_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("ovf_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("ovf_rsp_id", 64'(bus.rsp_id), 64'd1);
    checkOutput("ovf_rsp_out", 64'(bus.rsp_out), 64'h80000000);
    checkOutput("ovf_rsp_flags", 64'(bus.rsp_flags), 64'b1010);
    bus.rsp_ready = 1'b1;
    tick();

    // 4: contention with both valid and rsp_ready held high
    applyStimulus(1'b1, 32'd10, 32'd20, 1'b1, 32'd100, 32'd200, 1'b1);
    for (int k = 0; k < 4; k++) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
      expGrant = 1'b0;
`else
      expGrant = k[0];
`endif
      #1;
      checkOutput($sformatf("cont%0d_ready0", k), 64'(bus.req0_ready), 64'(!expGrant));
      checkOutput($sformatf("cont%0d_ready1", k), 64'(bus.req1_ready), 64'(expGrant));
      tick();
      tick();
      tick();
      checkOutput($sformatf("cont%0d_rsp_valid", k), 64'(bus.rsp_valid), 64'd1);
      checkOutput($sformatf("cont%0d_rsp_id", k), 64'(bus.rsp_id), 64'(expGrant));
      checkOutput($sformatf("cont%0d_rsp_out", k), 64'(bus.rsp_out),
                  expGrant ? 64'd300 : 64'd30);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();

    // 5: backpressure in RESP, with requester 1 waiting
    applyStimulus(1'b1, 32'd5, 32'd6, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("bp_ready0", 64'(bus.req0_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'd3, 32'd4, 1'b0);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp%0d_rsp_valid", c), 64'(bus.rsp_valid), 64'd1);
      checkOutput($sformatf("bp%0d_rsp_id", c), 64'(bus.rsp_id), 64'd0);
      checkOutput($sformatf("bp%0d_rsp_out", c), 64'(bus.rsp_out), 64'd11);
      checkOutput($sformatf("bp%0d_rsp_flags", c), 64'(bus.rsp_flags), 64'b0000);
      checkOutput($sformatf("bp%0d_ready0", c), 64'(bus.req0_ready), 64'd0);
      checkOutput($sformatf("bp%0d_ready1", c), 64'(bus.req1_ready), 64'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checkOutput("bp_release_busy", 64'(busy), 64'd0);
    checkOutput("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("bp_next_ready1", 64'(bus.req1_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("bp_next_busy", 64'(busy), 64'd1);
    checkOutput("bp_next_ula_a", 64'(bus.ula_a), 64'd3);
    tick();
    tick();
    checkOutput("bp_next_rsp_id", 64'(bus.rsp_id), 64'd1);
    checkOutput("bp_next_rsp_out", 64'(bus.rsp_out), 64'd7);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // 6: reset mid-op. A requester 0 op first makes the last grant 0.
    applyStimulus(1'b1, 32'd9, 32'd1, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("abort_pre_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("abort_ula_a", 64'(bus.ula_a), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput($sformatf("abort_quiet%0d", c), 64'(bus.rsp_valid), 64'd0);
    end
    applyStimulus(1'b1, 32'd1, 32'd1, 1'b1, 32'd2, 32'd2, 1'b0);
    #1;
    checkOutput("abort_lastgrant_r0", 64'(bus.req0_ready), 64'd1);
    checkOutput("abort_lastgrant_r1", 64'(bus.req1_ready), 64'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("abort_after_id", 64'(bus.rsp_id), 64'd0);
    checkOutput("abort_after_out", 64'(bus.rsp_out), 64'd2);
    bus.rsp_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
